// File: rtl/qos_pkg.sv
// Shared constants and the config-register bundle for the QoS selector register block.
package qos_pkg;

    localparam int unsigned ADDR_CONFIG = 32'h00;
    localparam int unsigned ADDR_STATUS = 32'h01;
    localparam int unsigned ADDR_ERRCNT = 32'h02;
    localparam int unsigned ADDR_ERRCLR = 32'h03;

    localparam int unsigned CFG_FALLBACK_BIT = 0;
    localparam int unsigned CFG_MANUAL_BIT   = 1;
    localparam int unsigned CFG_MCHAN_LSB    = 2;
    localparam int unsigned CFG_MCHAN_W      = 2;
    localparam int unsigned CFG_PRIO_LSB     = 4;
    localparam int unsigned CFG_PRIO_W       = 8;
    localparam int unsigned CFG_TIMER_LSB    = 12;
    localparam int unsigned CFG_TIMER_W      = 20;

    localparam logic [31:0] CONFIG_RST = 32'h0000_0E42;

    // Packed so that the struct overlays the CONFIG word bit-for-bit.
    typedef struct packed {
        logic [CFG_TIMER_W-1:0] reset_timer;
        logic [CFG_PRIO_W-1:0]  channel_priority;
        logic [CFG_MCHAN_W-1:0] manual_channel;
        logic                   manual_enable;
        logic                   fallback_enable;
    } cfg_t;

endpackage

// File: rtl/qos_err_counter.sv
// Saturating per-channel TS error counter; a clear coinciding with an error loads 1.
module qos_err_counter #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 rclk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? CNT_WIDTH'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/qos_mm_regs.sv
// Memory-mapped config/status/error-counter responder for the QoS channel selector.
module qos_mm_regs
    import qos_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned TIMER_WIDTH = 20
) (
    input  logic                   rclk,
    input  logic                   rst,
    input  logic                   mm_write_en,
    input  logic                   mm_read_en,
    input  logic [ADDR_WIDTH-1:0]  mm_addr,
    input  logic [DATA_WIDTH-1:0]  mm_wdata,
    output logic [DATA_WIDTH-1:0]  mm_rdata,
    output logic                   mm_rvalid,
    input  logic [NUM_CH-1:0]      err_pulse,
    input  logic [1:0]             active_channel,
    input  logic [NUM_CH-1:0]      signal_present,
    output logic                   fallback_enable,
    output logic                   manual_enable,
    output logic [1:0]             manual_channel,
    output logic [7:0]             channel_priority,
    output logic [TIMER_WIDTH-1:0] reset_timer,
    output logic                   cfg_update
);

    cfg_t                             cfg_q, cfg_d;
    logic [TIMER_WIDTH-1:0]           timer_q, timer_d;
    logic                             cfg_update_q, cfg_update_d;
    logic [DATA_WIDTH-1:0]            rdata_q, rdata_d;
    logic                             rvalid_q, rvalid_d;
    logic                             win_clear;
    logic                             wr_cfg, wr_clr;
    logic [NUM_CH-1:0]                cnt_clr;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt;

    assign wr_cfg = mm_write_en && (mm_addr == ADDR_WIDTH'(ADDR_CONFIG));
    assign wr_clr = mm_write_en && (mm_addr == ADDR_WIDTH'(ADDR_ERRCLR));

    always_comb begin
        cfg_d        = cfg_q;
        cfg_update_d = wr_cfg;
        if (wr_cfg) begin
            cfg_d = cfg_t'(mm_wdata[31:0]);
        end
    end

    // Window timer runs off the committed reset_timer; a CONFIG write restarts it.
    always_comb begin
        win_clear = 1'b0;
        timer_d   = timer_q;
        if (cfg_q.reset_timer == '0) begin
            timer_d = '0;
        end else if (timer_q == cfg_q.reset_timer - TIMER_WIDTH'(1)) begin
            win_clear = 1'b1;
            timer_d   = '0;
        end else begin
            timer_d = timer_q + TIMER_WIDTH'(1);
        end
        if (wr_cfg) begin
            timer_d = '0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        assign cnt_clr[i] = win_clear || (wr_clr && mm_wdata[i]);

        qos_err_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .rclk  (rclk),
            .rst   (rst),
            .inc   (err_pulse[i]),
            .clr   (cnt_clr[i]),
            .count (cnt[i])
        );
    end

    // CONFIG reads return cfg_q, i.e. the value before any same-cycle write.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = mm_read_en;
        if (mm_read_en) begin
            case (mm_addr)
                ADDR_WIDTH'(ADDR_CONFIG): rdata_d = DATA_WIDTH'(cfg_q);
                ADDR_WIDTH'(ADDR_STATUS): rdata_d = DATA_WIDTH'({signal_present, active_channel});
                ADDR_WIDTH'(ADDR_ERRCNT): rdata_d = DATA_WIDTH'(cnt);
                default:                  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            cfg_q        <= cfg_t'(CONFIG_RST);
            timer_q      <= '0;
            cfg_update_q <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            cfg_q        <= cfg_d;
            timer_q      <= timer_d;
            cfg_update_q <= cfg_update_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign fallback_enable  = cfg_q.fallback_enable;
    assign manual_enable    = cfg_q.manual_enable;
    assign manual_channel   = cfg_q.manual_channel;
    assign channel_priority = cfg_q.channel_priority;
    assign reset_timer      = cfg_q.reset_timer;
    assign cfg_update       = cfg_update_q;
    assign mm_rdata         = rdata_q;
    assign mm_rvalid        = rvalid_q;

endmodule

// File: tb/tb_qos_mm_regs.sv
// Scoreboard bench for qos_mm_regs: expected read data queued at issue, checked on mm_rvalid.
module tb_qos_mm_regs;

    logic        rclk = 1'b0;
    logic        rst  = 1'b1;
    logic        mm_write_en = 1'b0;
    logic        mm_read_en  = 1'b0;
    logic [7:0]  mm_addr     = '0;
    logic [31:0] mm_wdata    = '0;
    logic [31:0] mm_rdata;
    logic        mm_rvalid;
    logic [3:0]  err_pulse      = '0;
    logic [1:0]  active_channel = '0;
    logic [3:0]  signal_present = '0;
    logic        fallback_enable;
    logic        manual_enable;
    logic [1:0]  manual_channel;
    logic [7:0]  channel_priority;
    logic [19:0] reset_timer;
    logic        cfg_update;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] mon_exp;
    string       mon_tag;

    qos_mm_regs u_dut (
        .rclk             (rclk),
        .rst              (rst),
        .mm_write_en      (mm_write_en),
        .mm_read_en       (mm_read_en),
        .mm_addr          (mm_addr),
        .mm_wdata         (mm_wdata),
        .mm_rdata         (mm_rdata),
        .mm_rvalid        (mm_rvalid),
        .err_pulse        (err_pulse),
        .active_channel   (active_channel),
        .signal_present   (signal_present),
        .fallback_enable  (fallback_enable),
        .manual_enable    (manual_enable),
        .manual_channel   (manual_channel),
        .channel_priority (channel_priority),
        .reset_timer      (reset_timer),
        .cfg_update       (cfg_update)
    );

    always #5 rclk = ~rclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge rclk) begin
        if (mm_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("rvalid_spurious", 32'(mm_rvalid), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                check_eq(mon_tag, mm_rdata, mon_exp);
            end
        end
    end

    // Both tasks are entered at a falling edge and return at the next one.
    task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        mm_read_en = 1'b1;
        mm_addr    = addr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge rclk);
        mm_read_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        mm_write_en = 1'b1;
        mm_addr     = addr;
        mm_wdata    = data;
        @(negedge rclk);
        mm_write_en = 1'b0;
    endtask

    task automatic check_cfg_reset(input string tag);
        check_eq({tag, "_cfg"}, {reset_timer, channel_priority, manual_channel,
                                 manual_enable, fallback_enable}, 32'h0000_0E42);
        check_eq({tag, "_rdata"}, mm_rdata, 32'h0);
        check_eq({tag, "_rvalid"}, 32'(mm_rvalid), 32'h0);
        check_eq({tag, "_cfg_update"}, 32'(cfg_update), 32'h0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge rclk);
        check_cfg_reset("reset");
        check_eq("reset_manual_enable", 32'(manual_enable), 32'd1);
        check_eq("reset_priority", 32'(channel_priority), 32'hE4);
        rst = 1'b0;
        @(negedge rclk);

        signal_present = 4'b1010;
        active_channel = 2'b01;
        rd(8'h00, 32'h0000_0E42, "rd_config_reset");
        rd(8'h01, 32'h0000_0029, "rd_status_a");
        signal_present = 4'b0101;
        active_channel = 2'b10;
        rd(8'h01, 32'h0000_0016, "rd_status_b");
        @(negedge rclk);

        // CONFIG write: timer=50000, priority=D8, manual=0, fallback=1
        wr(8'h00, 32'h0C35_0D81);
        check_eq("wr_cfg_update", 32'(cfg_update), 32'd1);
        check_eq("wr_fallback", 32'(fallback_enable), 32'd1);
        check_eq("wr_manual", 32'(manual_enable), 32'd0);
        check_eq("wr_mchan", 32'(manual_channel), 32'd0);
        check_eq("wr_priority", 32'(channel_priority), 32'hD8);
        check_eq("wr_timer", 32'(reset_timer), 32'd50000);
        @(negedge rclk);
        check_eq("cfg_update_single", 32'(cfg_update), 32'd0);
        rd(8'h00, 32'h0C35_0D81, "rd_config_new");

        // Counters with timer disabled; channel 1 saturates
        wr(8'h00, 32'h0000_0D81);
        for (int i = 0; i < 300; i++) begin
            err_pulse = {1'b0, (i < 3), 1'b1, 1'b0};
            @(negedge rclk);
        end
        err_pulse = '0;
        rd(8'h02, 32'h0003_FF00, "rd_errcnt_sat");
        for (int i = 0; i < 7; i++) begin
            err_pulse = {1'b1, 1'b0, 1'b0, (i < 5)};
            @(negedge rclk);
        end
        err_pulse = '0;
        rd(8'h02, 32'h0703_FF05, "rd_errcnt_all");

        // Software clear, clear-vs-increment, ignored writes, unmapped reads
        wr(8'h03, 32'h0000_0005);
        rd(8'h02, 32'h0700_FF00, "rd_errclr_5");
        err_pulse = 4'b0001;
        wr(8'h03, 32'h0000_0001);
        err_pulse = '0;
        rd(8'h02, 32'h0700_FF01, "rd_errclr_inc");
        rd(8'h03, 32'h0, "rd_errclr_zero");
        wr(8'h01, 32'hFFFF_FFFF);
        check_eq("wr_ro_no_update", 32'(cfg_update), 32'd0);
        wr(8'h7F, 32'hFFFF_FFFF);
        check_eq("wr_unmapped_no_update", 32'(cfg_update), 32'd0);
        rd(8'h00, 32'h0000_0D81, "rd_config_unchanged");
        rd(8'h7F, 32'h0, "rd_unmapped");
        rd(8'h02, 32'h0700_FF01, "rd_errcnt_unchanged");

        // Window clear every 100 cycles; CONFIG write at k=150 restarts the window
        wr(8'h03, 32'h0000_000F);
        mm_write_en = 1'b1;
        mm_addr     = 8'h00;
        mm_wdata    = 32'h0006_4D81;
        err_pulse   = 4'b0001;
        for (int k = 0; k < 252; k++) begin
            @(negedge rclk);
            mm_write_en = (k == 150);
            mm_read_en  = 1'b0;
            mm_addr     = (k == 150) ? 8'h00 : 8'h02;
            if (k == 0 || k == 98 || k == 99 || k == 100 || k == 149) begin
                mm_read_en = 1'b1;
                exp_q.push_back(32'((k % 100) + 1));
                tag_q.push_back($sformatf("win_k%0d", k));
            end else if (k == 200 || k == 250 || k == 251) begin
                mm_read_en = 1'b1;
                exp_q.push_back((k == 251) ? 32'd1 : 32'(k - 99));
                tag_q.push_back($sformatf("win_restart_k%0d", k));
            end
        end
        @(negedge rclk);
        mm_write_en = 1'b0;
        mm_read_en  = 1'b0;
        err_pulse   = '0;
        check_eq("win_timer_field", 32'(reset_timer), 32'd100);

        // Simultaneous read and write of CONFIG
        mm_write_en = 1'b1;
        mm_read_en  = 1'b1;
        mm_addr     = 8'h00;
        mm_wdata    = 32'h0000_0A13;
        exp_q.push_back(32'h0006_4D81);
        tag_q.push_back("rdwr_old");
        @(negedge rclk);
        mm_write_en = 1'b0;
        mm_read_en  = 1'b0;
        check_eq("rdwr_cfg_update", 32'(cfg_update), 32'd1);
        rd(8'h00, 32'h0000_0A13, "rdwr_new");
        @(negedge rclk);

        // Reset mid-operation with a read in flight
        mm_read_en = 1'b1;
        mm_addr    = 8'h00;
        #2 rst = 1'b1;
        @(negedge rclk);
        mm_read_en = 1'b0;
        check_cfg_reset("midrst");
        @(negedge rclk);
        check_eq("midrst_rvalid_hold", 32'(mm_rvalid), 32'd0);
        rst = 1'b0;
        @(negedge rclk);
        rd(8'h00, 32'h0000_0E42, "midrst_rd_config");
        rd(8'h02, 32'h0, "midrst_rd_errcnt");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge rclk);
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
